dht_poll_scheduler: RTL

DHT_POLL_SCHEDULER -- requirements
Module: dht_poll_scheduler

---
 rtl/dht_poll_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dht_poll_scheduler.sv
// Arbitrates two clients and an optional autonomous timer onto one DHT reader, enforcing minimum gap, timeout and retries.
// req-to-rd_start is 2 clks once the gap has elapsed; requests are level-held and acknowledged by a 1-clk ack pulse, no other backpressure.
module dht_poll_scheduler #(
    parameter int CLK_PER_US     = 50,
    parameter int MIN_GAP_US     = 2_000_000,
    parameter int TIMEOUT_US     = 30_000,
    parameter int MAX_RETRY      = 3,
    parameter int AUTO_PERIOD_US = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_ok,
    input  logic [15:0] rd_data,
    output logic [15:0] TempHumi,
    output logic        th_valid,
    output logic        err
);

    localparam int US_W   = (CLK_PER_US > 1)     ? $clog2(CLK_PER_US)         : 1;
    localparam int GAP_W  = (MIN_GAP_US > 0)     ? $clog2(MIN_GAP_US + 1)     : 1;
    localparam int TO_W   = (TIMEOUT_US > 0)     ? $clog2(TIMEOUT_US + 1)     : 1;
    localparam int AUTO_W = (AUTO_PERIOD_US > 0) ? $clog2(AUTO_PERIOD_US + 1) : 1;
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);

    localparam logic [US_W-1:0]   US_LAST  = US_W'(CLK_PER_US - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_GAP_US);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_US);
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD_US);
    localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic              AUTO_EN  = (AUTO_PERIOD_US != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [US_W-1:0]    r_us_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [TO_W-1:0]    r_to;
    logic [AUTO_W-1:0]  r_auto;
    logic [RTY_W-1:0]   r_fail;
    logic [1:0]         r_mask;
    logic [15:0]        r_temp_humi;
    logic               r_th_valid;
    logic               r_err;

    logic               w_tick;
    logic               w_gap_done;
    logic               w_to_hit;
    logic               w_auto_hit;
    logic [RTY_W-1:0]   w_fail_nxt;
    logic               w_latch;
    logic               w_gap_clr;
    logic               w_to_clr;
    logic               w_auto_clr;
    logic               w_load_ok;
    logic               w_fail;
    logic               w_exhaust;
    logic               w_fail_clr;

    assign w_tick     = (r_us_cnt == US_LAST);
    assign w_gap_done = (r_gap == GAP_MAX);
    assign w_to_hit   = (r_to == TO_MAX);
    assign w_auto_hit = AUTO_EN && (r_auto == AUTO_MAX);
    assign w_fail_nxt = r_fail + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_gap_clr   = 1'b0;
        w_to_clr    = 1'b0;
        w_auto_clr  = 1'b0;
        w_load_ok   = 1'b0;
        w_fail      = 1'b0;
        w_exhaust   = 1'b0;
        w_fail_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A client request absorbs a coincident auto expiry; either way the auto timer restarts.
                if ((|req) || w_auto_hit) begin
                    w_latch     = 1'b1;
                    w_auto_clr  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_to_clr    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rd_done && rd_ok) begin
                    w_load_ok   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (rd_done || w_to_hit) begin
                    w_fail = 1'b1;
                    if (w_fail_nxt <= RTY_MAX) begin
                        w_gap_clr   = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_exhaust   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_gap_clr   = 1'b1;
                w_auto_clr  = 1'b1;
                w_fail_clr  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_us_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_us_cnt <= w_tick ? '0 : r_us_cnt + 1'b1;
        end
    end

    // All us timers saturate at their terminal value so long idle periods never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap  <= '0;
            r_to   <= '0;
            r_auto <= '0;
        end else begin
            if (w_gap_clr) begin
                r_gap <= '0;
            end else if (w_tick && !w_gap_done) begin
                r_gap <= r_gap + 1'b1;
            end

            if (w_to_clr) begin
                r_to <= '0;
            end else if ((r_state == S_WAIT) && w_tick && !w_to_hit) begin
                r_to <= r_to + 1'b1;
            end

            if (!AUTO_EN || w_auto_clr) begin
                r_auto <= '0;
            end else if (w_tick && (r_auto != AUTO_MAX)) begin
                r_auto <= r_auto + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail      <= '0;
            r_mask      <= 2'b00;
            r_temp_humi <= 16'h0000;
            r_th_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_fail_clr) begin
                r_fail <= '0;
            end else if (w_fail) begin
                r_fail <= w_fail_nxt;
            end

            if (w_latch) begin
                r_mask <= req;
            end

            if (w_load_ok) begin
                r_temp_humi <= rd_data;
                r_th_valid  <= 1'b1;
                r_err       <= 1'b0;
            end else if (w_exhaust) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_start = (r_state == S_START);
    assign ack      = (r_state == S_DONE) ? r_mask : 2'b00;
    assign TempHumi = r_temp_humi;
    assign th_valid = r_th_valid;
    assign err      = r_err;

endmodule
